// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8-bit asynchronous serial receiver, 16x oversampled with a 2-of-3 mid-bit vote.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module uart_rx_frame #(
  parameter int unsigned PrSv_ClkFreq_c = 100000000,
  parameter int unsigned PrSv_Baud_c    = 115200,
  parameter int unsigned PrSv_Div_c     = PrSv_ClkFreq_c / (PrSv_Baud_c * 16)
) (
  input  logic       CpSl_Clk_i,
  input  logic       CpSl_Rst_iN,
  input  logic       CpSl_RxData_i,
  output logic [7:0] CpSv_RxByte_o,
  output logic       CpSl_RxVld_o,
  output logic       CpSl_FrmErr_o,
  output logic       CpSl_PrtErr_o,
  output logic       CpSl_Busy_o
);

  localparam int unsigned DivW = $clog2(PrSv_Div_c);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BRK    = 3'd5;

  logic [2:0]      state, state_nxt;
  logic            sync1, sync2, hist;
  logic [1:0]      warm;
  logic [DivW-1:0] tick_cnt;
  logic [3:0]      samp_cnt;
  logic            s7, s8;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic [7:0]      rx_byte;
  logic            rx_vld, frm_err, busy;

  logic fall_c, tick_c, mid_c, wrap_c, maj_c;
  logic shift_c, load_c, frm_c;

  // Start edges only count once the synchronizer holds post-reset samples,
  // so a line already low when reset releases is not taken as a start bit.
  assign fall_c = (warm == 2'd3) && hist && !sync2;
  assign tick_c = (tick_cnt == DivW'(PrSv_Div_c - 1));
  assign mid_c  = tick_c && (samp_cnt == 4'd8);
  assign wrap_c = tick_c && (samp_cnt == 4'd15);
  assign maj_c  = (s7 & s8) | (s7 & sync2) | (s8 & sync2);

  // State register
  always_ff @(posedge CpSl_Clk_i or negedge CpSl_Rst_iN) begin
    if (!CpSl_Rst_iN) state <= IDLE;
    else              state <= state_nxt;
  end

  // Next-state and datapath controls
  always_comb begin
    state_nxt = state;
    shift_c   = 1'b0;
    load_c    = 1'b0;
    frm_c     = 1'b0;
    case (state)
      IDLE:  if (fall_c) state_nxt = START;
      START: begin
        if (mid_c && maj_c) state_nxt = IDLE;
        else if (wrap_c)    state_nxt = DATA;
      end
      DATA: begin
        shift_c = mid_c;
`ifdef UART_RX_PARITY_EN
        if (wrap_c && (bit_idx == 3'd7)) state_nxt = PARITY;
`else
        if (wrap_c && (bit_idx == 3'd7)) state_nxt = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (wrap_c) state_nxt = STOP;
`endif
      STOP: begin
        if (mid_c) begin
          if (maj_c) begin
            load_c    = 1'b1;
            state_nxt = IDLE;
          end else begin
            frm_c     = 1'b1;
            state_nxt = BRK;
          end
        end
      end
      BRK:     if (sync2) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Synchronizer, bit timing and sample capture
  always_ff @(posedge CpSl_Clk_i or negedge CpSl_Rst_iN) begin
    if (!CpSl_Rst_iN) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      hist     <= 1'b1;
      warm     <= 2'd0;
      tick_cnt <= '0;
      samp_cnt <= 4'd0;
      s7       <= 1'b1;
      s8       <= 1'b1;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
    end else begin
      sync1 <= CpSl_RxData_i;
      sync2 <= sync1;
      hist  <= sync2;
      if (warm != 2'd3) warm <= warm + 2'd1;
      if (state == IDLE) begin
        tick_cnt <= '0;
        samp_cnt <= 4'd0;
        bit_idx  <= 3'd0;
      end else begin
        tick_cnt <= tick_c ? '0 : tick_cnt + DivW'(1);
        if (tick_c) samp_cnt <= samp_cnt + 4'd1;
        if (tick_c && (samp_cnt == 4'd6)) s7 <= sync2;
        if (tick_c && (samp_cnt == 4'd7)) s8 <= sync2;
        if (wrap_c && (state == DATA)) bit_idx <= bit_idx + 3'd1;
      end
      if (shift_c) shreg <= {maj_c, shreg[7:1]};
    end
  end

  // Registered outputs
  always_ff @(posedge CpSl_Clk_i or negedge CpSl_Rst_iN) begin
    if (!CpSl_Rst_iN) begin
      rx_byte <= 8'h00;
      rx_vld  <= 1'b0;
      frm_err <= 1'b0;
      busy    <= 1'b0;
    end else begin
      if (load_c) rx_byte <= shreg;
      rx_vld  <= load_c;
      frm_err <= frm_c;
      busy    <= (state_nxt != IDLE);
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit, prt_err;

  // Parity bit captured at its own mid-bit; checked with the stop-bit decision
  always_ff @(posedge CpSl_Clk_i or negedge CpSl_Rst_iN) begin
    if (!CpSl_Rst_iN) begin
      par_bit <= 1'b0;
      prt_err <= 1'b0;
    end else begin
      if (mid_c && (state == PARITY)) par_bit <= maj_c;
      prt_err <= load_c && ((^shreg) ^ par_bit);
    end
  end
  assign CpSl_PrtErr_o = prt_err;
`else
  assign CpSl_PrtErr_o = 1'b0;
`endif

  assign CpSv_RxByte_o = rx_byte;
  assign CpSl_RxVld_o  = rx_vld;
  assign CpSl_FrmErr_o = frm_err;
  assign CpSl_Busy_o   = busy;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed frame vectors plus hand-written glitch, back-to-back and reset sequences.
// Runs the receiver at 781250 baud on 100 MHz (divider 8, 128 clocks per bit).
module tb_uart_rx_frame;

  localparam int unsigned Baud = 781250;
  localparam int          Bclk = 128;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line = 1'b1;
  logic [7:0] rx_byte;
  logic       vld, frm, prt, busy;

  uart_rx_frame #(
    .PrSv_ClkFreq_c(100000000),
    .PrSv_Baud_c   (Baud)
  ) dut (
    .CpSl_Clk_i   (clk),
    .CpSl_Rst_iN  (rst_n),
    .CpSl_RxData_i(line),
    .CpSv_RxByte_o(rx_byte),
    .CpSl_RxVld_o (vld),
    .CpSl_FrmErr_o(frm),
    .CpSl_PrtErr_o(prt),
    .CpSl_Busy_o  (busy)
  );

  always #5 clk = ~clk;

  int         vld_cyc = 0, frm_cyc = 0, prt_cyc = 0, busy_cyc = 0;
  logic [7:0] got_q[$];

  // Count strobe cycles away from the active edge; a clean strobe adds exactly one
  always @(negedge clk) begin
    if (vld) begin
      vld_cyc++;
      got_q.push_back(rx_byte);
    end
    if (frm)  frm_cyc++;
    if (prt)  prt_cyc++;
    if (busy) busy_cyc++;
  end

  int   n_vec = 0, n_bad = 0;
  logic busy_mid;

  task automatic check(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp_v, exp_v);
    end
  endtask

  // Drive one frame on negedges; busy is sampled at the start of data bit 4
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int bclk, input int idle);
    line = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) busy_mid = busy;
      line = d[i];
      repeat (bclk) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    line = par;
    repeat (bclk) @(negedge clk);
`else
    if (par === 1'bx) line = 1'b1;
`endif
    line = stop;
    repeat (bclk) @(negedge clk);
    line = 1'b1;
    repeat (idle) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         bclk;
    int         exp_vld;
    logic [7:0] exp_byte;
    int         exp_frm;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int b_vld, b_frm, b_prt, b_busy, base;

    vecs[0] = '{8'h55, 1'b1, Bclk,     1, 8'h55, 0};
    vecs[1] = '{8'h3C, 1'b0, Bclk,     0, 8'h55, 1};
    vecs[2] = '{8'h81, 1'b1, Bclk,     1, 8'h81, 0};
    vecs[3] = '{8'h00, 1'b1, Bclk,     1, 8'h00, 0};
    vecs[4] = '{8'hFF, 1'b1, Bclk,     1, 8'hFF, 0};
    vecs[5] = '{8'h01, 1'b1, Bclk - 3, 1, 8'h01, 0};
    vecs[6] = '{8'h80, 1'b1, Bclk + 3, 1, 8'h80, 0};

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_byte", int'(rx_byte), 0);
    check("rst_vld",  int'(vld), 0);
    check("rst_frm",  int'(frm), 0);
    check("rst_prt",  int'(prt), 0);
    check("rst_busy", int'(busy), 0);

    // Line already low when reset releases: no start, no framing error
    line = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    b_busy = busy_cyc; b_frm = frm_cyc;
    repeat (300) @(negedge clk);
    line = 1'b1;
    repeat (100) @(negedge clk);
    check("lowrel_busy", busy_cyc - b_busy, 0);
    check("lowrel_frm",  frm_cyc - b_frm, 0);

    // Table of frames
    foreach (vecs[k]) begin
      b_vld = vld_cyc; b_frm = frm_cyc; b_prt = prt_cyc;
      send_frame(vecs[k].data, ^vecs[k].data, vecs[k].stop, vecs[k].bclk, 2 * Bclk);
      check($sformatf("v%0d_vld", k),  vld_cyc - b_vld, vecs[k].exp_vld);
      check($sformatf("v%0d_frm", k),  frm_cyc - b_frm, vecs[k].exp_frm);
      check($sformatf("v%0d_prt", k),  prt_cyc - b_prt, 0);
      check($sformatf("v%0d_byte", k), int'(rx_byte), int'(vecs[k].exp_byte));
      check($sformatf("v%0d_busymid", k), int'(busy_mid), 1);
      check($sformatf("v%0d_busyend", k), int'(busy), 0);
    end

    // 300 ns glitch on idle line: false start, then a good frame
    b_vld = vld_cyc; b_frm = frm_cyc; b_busy = busy_cyc;
    line = 1'b0;
    repeat (30) @(negedge clk);
    line = 1'b1;
    repeat (2 * Bclk) @(negedge clk);
    check("glitch_busyseen", int'(busy_cyc > b_busy), 1);
    check("glitch_vld",  vld_cyc - b_vld, 0);
    check("glitch_frm",  frm_cyc - b_frm, 0);
    check("glitch_busy", int'(busy), 0);
    send_frame(8'hA5, 1'b0, 1'b1, Bclk, 2 * Bclk);
    check("glitch_next_vld",  vld_cyc - b_vld, 1);
    check("glitch_next_byte", int'(rx_byte), 8'hA5);

    // Back-to-back frames, zero idle, transmitter about 2% fast
    b_vld = vld_cyc; base = got_q.size();
    send_frame(8'hA5, 1'b0, 1'b1, Bclk - 3, 0);
    send_frame(8'h3C, 1'b0, 1'b1, Bclk - 3, 2 * Bclk);
    check("b2b_vld", vld_cyc - b_vld, 2);
    check("b2b_byte0", (got_q.size() > base)     ? int'(got_q[base])     : -1, 8'hA5);
    check("b2b_byte1", (got_q.size() > base + 1) ? int'(got_q[base + 1]) : -1, 8'h3C);

    // Reset during data bit 4 of 0xF0
    b_vld = vld_cyc; b_frm = frm_cyc;
    fork
      send_frame(8'hF0, 1'b0, 1'b1, Bclk, 2 * Bclk);
      begin
        repeat (5 * Bclk + 20) @(negedge clk);
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_byte", int'(rx_byte), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_vld",  int'(vld), 0);
        rst_n = 1'b1;
      end
    join
    check("midrst_novld", vld_cyc - b_vld, 0);
    check("midrst_nofrm", frm_cyc - b_frm, 0);
    send_frame(8'h0F, 1'b0, 1'b1, Bclk, 2 * Bclk);
    check("postrst_vld",  vld_cyc - b_vld, 1);
    check("postrst_byte", int'(rx_byte), 8'h0F);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so parity bit 1 is correct
    b_vld = vld_cyc; b_prt = prt_cyc;
    send_frame(8'h07, 1'b1, 1'b1, Bclk, 2 * Bclk);
    check("par_ok_vld", vld_cyc - b_vld, 1);
    check("par_ok_prt", prt_cyc - b_prt, 0);
    send_frame(8'h07, 1'b0, 1'b1, Bclk, 2 * Bclk);
    check("par_bad_vld",  vld_cyc - b_vld, 2);
    check("par_bad_prt",  prt_cyc - b_prt, 1);
    check("par_bad_byte", int'(rx_byte), 8'h07);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
